// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU/MDU definitions: ALU function codes, MDU opcodes and MDU
// sequencer state encoding.
package mips_alu_pkg;

  localparam logic [2:0] ALU_F_AND = 3'b000;
  localparam logic [2:0] ALU_F_ADD = 3'b010;
  localparam logic [2:0] ALU_F_SUB = 3'b110;

  localparam logic MDU_OP_MULTU = 1'b0;
  localparam logic MDU_OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the shared ALU for one
// shift-add / restoring-subtract iteration per clock; results land in HI/LO.
module mdu_sequencer
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_carry
);

  mdu_state_t       state_r;
  mdu_state_t       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             op_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] hi_s;
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH-1:0] rem_shift_s;
  logic             accept_s;
  logic             last_iter_s;

  // Divide works on the remainder shifted left by one with the next dividend bit.
  assign rem_shift_s = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

  // ALU operand/function drive: only claims the ALU while iterating.
  always_comb begin
    alu_f = ALU_F_AND;
    alu_a = {WIDTH{1'b0}};
    alu_b = {WIDTH{1'b0}};
    if (state_r == RUN) begin
      if (op_r == MDU_OP_MULTU) begin
        alu_f = ALU_F_ADD;
        alu_a = hi;
        alu_b = lo[0] ? b_r : {WIDTH{1'b0}};
      end else begin
        alu_f = ALU_F_SUB;
        alu_a = rem_shift_s;
        alu_b = b_r;
      end
    end else begin
      alu_f = ALU_F_AND;
    end
  end

  // Next state and next HI/LO for one iteration.
  always_comb begin
    state_s  = state_r;
    hi_s     = hi;
    lo_s     = lo;
    accept_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        state_s = last_iter_s ? DONE : RUN;
        if (op_r == MDU_OP_MULTU) begin
          {hi_s, lo_s} = {alu_carry, alu_y, lo[WIDTH-1:1]};
        end else if (hi[WIDTH-1] | ~alu_carry) begin
          // A set top bit means the shifted remainder exceeds the divisor even
          // when the ALU reports a borrow; alu_y is still correct mod 2^WIDTH.
          hi_s = alu_y;
          lo_s = {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi_s = rem_shift_s;
          lo_s = {lo[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter, operand and result registers; busy/done registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= 1'b0;
      b_r     <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      busy    <= (state_s == RUN);
      done    <= (state_s == DONE);
      if (accept_s) begin
        op_r  <= op;
        b_r   <= src_b;
        cnt_r <= {CNT_W{1'b0}};
        dbz   <= op & (src_b == {WIDTH{1'b0}});
        hi    <= {WIDTH{1'b0}};
        lo    <= src_a;
      end else if (state_r == RUN) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        hi    <= hi_s;
        lo    <= lo_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule
